pong_match_engine: RTL and testbench
====================================

Name: pong_match_engine

Overview:
Parametrised successor to the Pong collision controller. It merges ball physics, both paddle movers, scoring and match sequencing into one block: serve delay, play, point, and game-over. Ball X speed ramps up on paddle hits. The block sits between the player input debouncers and the video renderer and is clocked by the frame-rate game clock.

Parameters:
COORD_W, 10, width of all coordinate outputs
X_LWALL, 0, left field bound (inclusive)
X_RWALL, 640, right field bound (exclusive)
Y_CEIL, 0, top bound (inclusive)
Y_FLOOR, 480, bottom bound (exclusive)
BALL_W, 8, ball width
BALL_H, 8, ball height
PAD_W, 8, paddle width
PAD_H, 64, paddle height
PAD_MARGIN, 16, gap between wall and paddle
PAD_VEL, 4, paddle step per tick
BALL_VX0, 2, initial X speed
BALL_VY, 2, Y speed (constant)
VX_MAX, 8, X speed ceiling
SPEEDUP, 1, 1 means X speed increments on each paddle hit
VEL_W, 4, width of the velocity output
SCORE_W, 3, width of each score counter
WIN_SCORE, 7, score that ends the match
SERVE_TICKS, 60, ticks spent in SERVE

Ports:
game_clk  in  1  game tick clock
reset  in  1  asynchronous, active-low reset
start  in  1  restarts the match from OVER
inputA_up / inputA_down / inputB_up / inputB_down  in  1 each  paddle controls
x_ball, y_ball  out  COORD_W  ball top-left position
x_ball_dir  out  1  1 means moving right
y_ball_dir  out  1  1 means moving down
x_ball_vel  out  VEL_W  current X speed
x_paddleA, x_paddleB  out  COORD_W  constants X_LWALL+PAD_MARGIN and X_RWALL-PAD_MARGIN-PAD_W
y_paddleA, y_paddleB  out  COORD_W  paddle top positions
scoreA, scoreB  out  SCORE_W  scores
lossA, lossB  out  1  one-tick pulse when that player concedes a point
wall_col, paddle_col  out  1  one-tick collision pulses
game_over  out  1  high while in OVER
winner  out  1  0 means A won, 1 means B won; valid while game_over is high
state  out  2  SERVE=0, PLAY=1, POINT=2, OVER=3

Behaviour:
- Reset (reset=0, async) sets the following; all pulses and game_over are 0:
  - state=SERVE, serve counter=0
  - scores=0, x_ball_vel=BALL_VX0
  - ball at centre: x=(X_LWALL+X_RWALL)/2-BALL_W/2, y=(Y_CEIL+Y_FLOOR)/2-BALL_H/2 (316,236 at defaults)
  - x_dir=1, y_dir=1, winner=0
  - paddles y=(Y_CEIL+Y_FLOOR)/2-PAD_H/2 (208)
- All registers update on the game_clk rising edge. Pulse outputs are registered and last exactly one cycle.
- Paddles move in every state except OVER:
  - up-only: y-=PAD_VEL; down-only: y+=PAD_VEL; both or neither: hold.
  - Clamp y to [Y_CEIL, Y_FLOOR-PAD_H]; no wrap or underflow.
- SERVE: ball is held at centre and the counter increments each tick. When the counter reaches SERVE_TICKS-1, go to PLAY and clear the counter.
- PLAY, Y axis:
  - Next y = y ± BALL_VY.
  - If the next y reaches or crosses Y_CEIL going up, or Y_FLOOR-BALL_H going down: clamp to that bound, flip y_dir, pulse wall_col.
- PLAY, X axis, moving left:
  - Paddle A hit requires x ≥ xA+PAD_W, x-vx ≤ xA+PAD_W, y_ball+BALL_H > y_paddleA and y_ball < y_paddleA+PAD_H (the Y terms use the pre-move ball y).
  - On a hit: x=xA+PAD_W, x_dir=1, pulse paddle_col, and vx=min(vx+1, VX_MAX) if SPEEDUP.
  - Otherwise, if x-vx ≤ X_LWALL (evaluate without underflow): x=X_LWALL, go to POINT, pulse lossA, scoreB+1.
- PLAY, X axis, moving right: mirror of the left case using xB, with the ball's right edge x+BALL_W and bound X_RWALL-BALL_W. A miss pulses lossB and gives scoreA+1.
- A wall hit and a paddle hit in the same tick both apply, and both pulses fire.
- POINT (one tick):
  - If the scorer's new score = WIN_SCORE, go to OVER with winner = scorer.
  - Otherwise go to SERVE: ball recentred, vx=BALL_VX0, x_dir points toward the player who conceded, y_dir keeps its value.
- OVER: ball frozen and game_over=1. start=1 clears the scores and reloads the reset values except paddle positions, then goes to SERVE. start is ignored in other states.
- Scores saturate at WIN_SCORE and never wrap.

Test Plan:
1. Release reset → 60 ticks in SERVE with ball at (316,236). Tick 61: state=PLAY, x=318, y=238.
2. Hold inputA_up for 60 ticks → y_paddleA decrements 4 per tick and stops at 0. Press both inputs → y_paddleA holds. inputB_down held → y_paddleB stops at 416.
3. Ball reaches the floor → y clamps to 472, y_dir=0, wall_col high for exactly one tick.
4. y_paddleB aligned with the ball → ball clamps to x=608, x_dir=0, paddle_col pulses, x_ball_vel 2→3. After six more hits, x_ball_vel=8 and stays at 8.
5. Paddle B parked at 0 while the ball passes low → x=632, lossB pulse, scoreA=1, state POINT then SERVE, ball at 316, x_dir=1, vx=2.
6. scoreA=6 followed by another miss by B → state=OVER, game_over=1, winner=0, ball frozen. start=1 → scores 0, state SERVE. Assert reset mid-PLAY → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pong_match_engine.sv
// Pong match engine: ball physics, both paddles, scoring and serve/play/point/over sequencing.
// Latency: every output is a register (or decoded from state_q) updated one game_clk tick after its cause.
// Backpressure: none; free-running on the game tick, control inputs sampled on every rising edge.
// Ports: game_clk, reset (async active-low), start, inputA_up/down, inputB_up/down in;
//        x/y_ball, x/y_ball_dir, x_ball_vel, x/y_paddleA/B, scoreA/B, lossA/B, wall_col,
//        paddle_col, game_over, winner, state out.
module pong_match_engine #(
   parameter int COORD_W     = 10,
   parameter int X_LWALL     = 0,
   parameter int X_RWALL     = 640,
   parameter int Y_CEIL      = 0,
   parameter int Y_FLOOR     = 480,
   parameter int BALL_W      = 8,
   parameter int BALL_H      = 8,
   parameter int PAD_W       = 8,
   parameter int PAD_H       = 64,
   parameter int PAD_MARGIN  = 16,
   parameter int PAD_VEL     = 4,
   parameter int BALL_VX0    = 2,
   parameter int BALL_VY     = 2,
   parameter int VX_MAX      = 8,
   parameter int SPEEDUP     = 1,
   parameter int VEL_W       = 4,
   parameter int SCORE_W     = 3,
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_TICKS = 60
) (
   input  logic               game_clk,
   input  logic               reset,
   input  logic               start,
   input  logic               inputA_up,
   input  logic               inputA_down,
   input  logic               inputB_up,
   input  logic               inputB_down,
   output logic [COORD_W-1:0] x_ball,
   output logic [COORD_W-1:0] y_ball,
   output logic               x_ball_dir,
   output logic               y_ball_dir,
   output logic [VEL_W-1:0]   x_ball_vel,
   output logic [COORD_W-1:0] x_paddleA,
   output logic [COORD_W-1:0] x_paddleB,
   output logic [COORD_W-1:0] y_paddleA,
   output logic [COORD_W-1:0] y_paddleB,
   output logic [SCORE_W-1:0] scoreA,
   output logic [SCORE_W-1:0] scoreB,
   output logic               lossA,
   output logic               lossB,
   output logic               wall_col,
   output logic               paddle_col,
   output logic               game_over,
   output logic               winner,
   output logic [1:0]         state
);

   typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

   localparam int X_CTR   = (X_LWALL + X_RWALL) / 2 - BALL_W / 2;
   localparam int Y_CTR   = (Y_CEIL + Y_FLOOR) / 2 - BALL_H / 2;
   localparam int PAD_CTR = (Y_CEIL + Y_FLOOR) / 2 - PAD_H / 2;
   localparam int XA      = X_LWALL + PAD_MARGIN;
   localparam int XB      = X_RWALL - PAD_MARGIN - PAD_W;
   localparam int XA_FACE = XA + PAD_W;      // ball x resting against A's face
   localparam int XB_FACE = XB - BALL_W;     // ball x resting against B's face
   localparam int X_MAXB  = X_RWALL - BALL_W;
   localparam int Y_MAXB  = Y_FLOOR - BALL_H;
   localparam int Y_MAXP  = Y_FLOOR - PAD_H;
   localparam int CNT_W   = $clog2(SERVE_TICKS + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d, pa_q, pa_d, pb_q, pb_d;
   logic               xdir_q, xdir_d, ydir_q, ydir_d;
   logic [VEL_W-1:0]   vx_q, vx_d;
   logic [SCORE_W-1:0] sa_q, sa_d, sb_q, sb_d;
   logic               lossa_q, lossa_d, lossb_q, lossb_d;
   logic               wall_q, wall_d, pad_q, pad_d, winner_q, winner_d;

   // Coordinate maths is done in signed 32-bit so subtractions never underflow.
   int   xi, yi, vxi, ny, vx_up;
   logic hit_a, hit_b;

   function automatic logic [COORD_W-1:0] pad_next(input logic [COORD_W-1:0] p,
                                                   input logic up, input logic dn);
      int n;
      n = int'(p);
      if (up && !dn)      n = (n - PAD_VEL < Y_CEIL) ? Y_CEIL : n - PAD_VEL;
      else if (dn && !up) n = (n + PAD_VEL > Y_MAXP) ? Y_MAXP : n + PAD_VEL;
      return COORD_W'(n);
   endfunction

   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
      return (int'(s) >= WIN_SCORE) ? s : s + 1'b1;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      xdir_d   = xdir_q;
      ydir_d   = ydir_q;
      vx_d     = vx_q;
      pa_d     = pa_q;
      pb_d     = pb_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      winner_d = winner_q;
      lossa_d  = 1'b0;
      lossb_d  = 1'b0;
      wall_d   = 1'b0;
      pad_d    = 1'b0;
      xi       = int'(x_q);
      yi       = int'(y_q);
      vxi      = int'(vx_q);
      ny       = yi;
      vx_up    = (SPEEDUP != 0 && vxi < VX_MAX) ? vxi + 1 : vxi;

      // Paddle hit tests use the ball y before this tick's vertical move.
      hit_a = (xi >= XA_FACE) && (xi - vxi <= XA_FACE) &&
              (yi + BALL_H > int'(pa_q)) && (yi < int'(pa_q) + PAD_H);
      hit_b = (xi + BALL_W <= XB) && (xi + BALL_W + vxi >= XB) &&
              (yi + BALL_H > int'(pb_q)) && (yi < int'(pb_q) + PAD_H);

      if (state_q != OVER) begin
         pa_d = pad_next(pa_q, inputA_up, inputA_down);
         pb_d = pad_next(pb_q, inputB_up, inputB_down);
      end

      case (state_q)
         SERVE: begin
            x_d = COORD_W'(X_CTR);
            y_d = COORD_W'(Y_CTR);
            if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
               state_d = PLAY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PLAY: begin
            if (ydir_q) begin
               ny = yi + BALL_VY;
               if (ny >= Y_MAXB) begin ny = Y_MAXB; ydir_d = 1'b0; wall_d = 1'b1; end
            end else begin
               ny = yi - BALL_VY;
               if (ny <= Y_CEIL) begin ny = Y_CEIL; ydir_d = 1'b1; wall_d = 1'b1; end
            end
            y_d = COORD_W'(ny);
            if (!xdir_q) begin
               if (hit_a) begin
                  x_d = COORD_W'(XA_FACE); xdir_d = 1'b1; pad_d = 1'b1; vx_d = VEL_W'(vx_up);
               end else if (xi - vxi <= X_LWALL) begin
                  x_d = COORD_W'(X_LWALL); state_d = POINT; lossa_d = 1'b1; sb_d = score_inc(sb_q);
               end else begin
                  x_d = COORD_W'(xi - vxi);
               end
            end else begin
               if (hit_b) begin
                  x_d = COORD_W'(XB_FACE); xdir_d = 1'b0; pad_d = 1'b1; vx_d = VEL_W'(vx_up);
               end else if (xi + vxi >= X_MAXB) begin
                  x_d = COORD_W'(X_MAXB); state_d = POINT; lossb_d = 1'b1; sa_d = score_inc(sa_q);
               end else begin
                  x_d = COORD_W'(xi + vxi);
               end
            end
         end
         POINT: begin
            // lossb_q is still high during this tick, so it names the scorer (A when set).
            if (lossb_q ? (int'(sa_q) == WIN_SCORE) : (int'(sb_q) == WIN_SCORE)) begin
               state_d  = OVER;
               winner_d = ~lossb_q;
            end else begin
               state_d = SERVE;
               x_d     = COORD_W'(X_CTR);
               y_d     = COORD_W'(Y_CTR);
               vx_d    = VEL_W'(BALL_VX0);
               xdir_d  = lossb_q;   // serve toward whoever conceded
            end
         end
         OVER: begin
            if (start) begin
               state_d  = SERVE;
               cnt_d    = '0;
               sa_d     = '0;
               sb_d     = '0;
               x_d      = COORD_W'(X_CTR);
               y_d      = COORD_W'(Y_CTR);
               vx_d     = VEL_W'(BALL_VX0);
               xdir_d   = 1'b1;
               ydir_d   = 1'b1;
               winner_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge game_clk or negedge reset) begin
      if (!reset) begin
         state_q  <= SERVE;
         cnt_q    <= '0;
         x_q      <= COORD_W'(X_CTR);
         y_q      <= COORD_W'(Y_CTR);
         xdir_q   <= 1'b1;
         ydir_q   <= 1'b1;
         vx_q     <= VEL_W'(BALL_VX0);
         pa_q     <= COORD_W'(PAD_CTR);
         pb_q     <= COORD_W'(PAD_CTR);
         sa_q     <= '0;
         sb_q     <= '0;
         winner_q <= 1'b0;
         lossa_q  <= 1'b0;
         lossb_q  <= 1'b0;
         wall_q   <= 1'b0;
         pad_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         xdir_q   <= xdir_d;
         ydir_q   <= ydir_d;
         vx_q     <= vx_d;
         pa_q     <= pa_d;
         pb_q     <= pb_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         winner_q <= winner_d;
         lossa_q  <= lossa_d;
         lossb_q  <= lossb_d;
         wall_q   <= wall_d;
         pad_q    <= pad_d;
      end
   end

   assign x_ball     = x_q;
   assign y_ball     = y_q;
   assign x_ball_dir = xdir_q;
   assign y_ball_dir = ydir_q;
   assign x_ball_vel = vx_q;
   assign x_paddleA  = COORD_W'(XA);
   assign x_paddleB  = COORD_W'(XB);
   assign y_paddleA  = pa_q;
   assign y_paddleB  = pb_q;
   assign scoreA     = sa_q;
   assign scoreB     = sb_q;
   assign lossA      = lossa_q;
   assign lossB      = lossb_q;
   assign wall_col   = wall_q;
   assign paddle_col = pad_q;
   assign game_over  = (state_q == OVER);
   assign winner     = winner_q;
   assign state      = state_q;

endmodule

// File: tb/tb_pong_match_engine.sv
module tb_pong_match_engine;

   logic       game_clk = 1'b0;
   logic       reset;
   logic       start;
   logic       inputA_up, inputA_down, inputB_up, inputB_down;
   logic [9:0] x_ball, y_ball, x_paddleA, x_paddleB, y_paddleA, y_paddleB;
   logic       x_ball_dir, y_ball_dir;
   logic [3:0] x_ball_vel;
   logic [2:0] scoreA, scoreB;
   logic       lossA, lossB, wall_col, paddle_col, game_over, winner;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;

   pong_match_engine dut (
      .game_clk(game_clk), .reset(reset), .start(start),
      .inputA_up(inputA_up), .inputA_down(inputA_down),
      .inputB_up(inputB_up), .inputB_down(inputB_down),
      .x_ball(x_ball), .y_ball(y_ball), .x_ball_dir(x_ball_dir), .y_ball_dir(y_ball_dir),
      .x_ball_vel(x_ball_vel), .x_paddleA(x_paddleA), .x_paddleB(x_paddleB),
      .y_paddleA(y_paddleA), .y_paddleB(y_paddleB), .scoreA(scoreA), .scoreB(scoreB),
      .lossA(lossA), .lossB(lossB), .wall_col(wall_col), .paddle_col(paddle_col),
      .game_over(game_over), .winner(winner), .state(state)
   );

   always #5 game_clk = ~game_clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge game_clk);
      #1;
   endtask

   task automatic clear_inputs();
      inputA_up = 1'b0; inputA_down = 1'b0; inputB_up = 1'b0; inputB_down = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      tick(2);
      total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
      total++; if (x_ball !== 10'd316 || y_ball !== 10'd236) begin bad++; $display("FAIL reset_ball: got %0d,%0d want 316,236", x_ball, y_ball); end
      total++; if (x_ball_dir !== 1'b1 || y_ball_dir !== 1'b1) begin bad++; $display("FAIL reset_dir: got %b%b want 11", x_ball_dir, y_ball_dir); end
      total++; if (x_ball_vel !== 4'd2) begin bad++; $display("FAIL reset_vel: got %0d want 2", x_ball_vel); end
      total++; if (y_paddleA !== 10'd208 || y_paddleB !== 10'd208) begin bad++; $display("FAIL reset_pad: got %0d,%0d want 208,208", y_paddleA, y_paddleB); end
      total++; if (x_paddleA !== 10'd16 || x_paddleB !== 10'd616) begin bad++; $display("FAIL pad_x: got %0d,%0d want 16,616", x_paddleA, x_paddleB); end
      total++; if (scoreA !== 3'd0 || scoreB !== 3'd0) begin bad++; $display("FAIL reset_score: got %0d,%0d want 0,0", scoreA, scoreB); end
      total++; if ({lossA, lossB, wall_col, paddle_col, game_over, winner} !== 6'b0) begin bad++; $display("FAIL reset_flags: got %b want 000000", {lossA, lossB, wall_col, paddle_col, game_over, winner}); end
      reset = 1'b1;
   endtask

   // Serve delay; paddle B is driven down throughout to check the bottom clamp.
   task automatic test_serve();
      inputB_down = 1'b1;
      tick(59);
      total++; if (state !== 2'd0 || x_ball !== 10'd316 || y_ball !== 10'd236) begin bad++; $display("FAIL serve_hold: got st=%0d %0d,%0d want 0 316,236", state, x_ball, y_ball); end
      total++; if (y_paddleB !== 10'd416) begin bad++; $display("FAIL padB_clamp: got %0d want 416", y_paddleB); end
      tick(1);
      total++; if (state !== 2'd1 || x_ball !== 10'd316) begin bad++; $display("FAIL serve_exit: got st=%0d x=%0d want 1 316", state, x_ball); end
      tick(1);
      total++; if (state !== 2'd1 || x_ball !== 10'd318 || y_ball !== 10'd238) begin bad++; $display("FAIL first_move: got st=%0d %0d,%0d want 1 318,238", state, x_ball, y_ball); end
      total++; if (y_paddleB !== 10'd416) begin bad++; $display("FAIL padB_hold: got %0d want 416", y_paddleB); end
      inputB_down = 1'b0;
   endtask

   task automatic test_paddle_a();
      inputA_up = 1'b1;
      tick(1);
      total++; if (y_paddleA !== 10'd204) begin bad++; $display("FAIL padA_step: got %0d want 204", y_paddleA); end
      tick(59);
      total++; if (y_paddleA !== 10'd0) begin bad++; $display("FAIL padA_top: got %0d want 0", y_paddleA); end
      inputA_up = 1'b0; inputA_down = 1'b1;
      tick(2);
      total++; if (y_paddleA !== 10'd8) begin bad++; $display("FAIL padA_down: got %0d want 8", y_paddleA); end
      inputA_up = 1'b1;
      tick(3);
      total++; if (y_paddleA !== 10'd8) begin bad++; $display("FAIL padA_both: got %0d want 8", y_paddleA); end
      clear_inputs();
   endtask

   task automatic test_wall();
      tick(51);
      total++; if (y_ball !== 10'd470 || y_ball_dir !== 1'b1 || wall_col !== 1'b0) begin bad++; $display("FAIL wall_pre: got y=%0d d=%b w=%b want 470 1 0", y_ball, y_ball_dir, wall_col); end
      tick(1);
      total++; if (y_ball !== 10'd472 || y_ball_dir !== 1'b0 || wall_col !== 1'b1) begin bad++; $display("FAIL wall_hit: got y=%0d d=%b w=%b want 472 0 1", y_ball, y_ball_dir, wall_col); end
      total++; if (x_ball !== 10'd552) begin bad++; $display("FAIL wall_x: got %0d want 552", x_ball); end
      tick(1);
      total++; if (y_ball !== 10'd470 || wall_col !== 1'b0) begin bad++; $display("FAIL wall_post: got y=%0d w=%b want 470 0", y_ball, wall_col); end
   endtask

   task automatic test_paddle_hit();
      tick(26);
      total++; if (x_ball !== 10'd606 || y_ball !== 10'd418 || paddle_col !== 1'b0) begin bad++; $display("FAIL hit_pre: got %0d,%0d p=%b want 606,418 0", x_ball, y_ball, paddle_col); end
      tick(1);
      total++; if (x_ball !== 10'd608 || x_ball_dir !== 1'b0 || paddle_col !== 1'b1) begin bad++; $display("FAIL hit_b: got x=%0d d=%b p=%b want 608 0 1", x_ball, x_ball_dir, paddle_col); end
      total++; if (x_ball_vel !== 4'd3 || y_ball !== 10'd416) begin bad++; $display("FAIL hit_vel: got v=%0d y=%0d want 3 416", x_ball_vel, y_ball); end
      tick(1);
      total++; if (x_ball !== 10'd605 || paddle_col !== 1'b0) begin bad++; $display("FAIL hit_post: got x=%0d p=%b want 605 0", x_ball, paddle_col); end
   endtask

   // Both paddles follow the ball; six more hits alternate A,B,... with speed 4,5,6,7,8,8.
   task automatic test_speed_ramp();
      int hits;
      int tgt;
      int ev;
      hits = 0;
      for (int cyc = 0; cyc < 3000 && hits < 6; cyc++) begin
         tgt = int'(y_ball) - 28;
         inputA_up   = (int'(y_paddleA) > tgt + 2);
         inputA_down = (int'(y_paddleA) < tgt - 2);
         inputB_up   = (int'(y_paddleB) > tgt + 2);
         inputB_down = (int'(y_paddleB) < tgt - 2);
         tick(1);
         total++; if (lossA !== 1'b0 || lossB !== 1'b0) begin bad++; $display("FAIL ramp_loss: got %b%b want 00", lossA, lossB); end
         if (paddle_col === 1'b1) begin
            ev = (hits < 4) ? hits + 4 : 8;
            total++; if (int'(x_ball_vel) != ev) begin bad++; $display("FAIL ramp_vel%0d: got %0d want %0d", hits, x_ball_vel, ev); end
            if (hits % 2 == 0) begin
               total++; if (x_ball !== 10'd24 || x_ball_dir !== 1'b1) begin bad++; $display("FAIL ramp_hitA%0d: got x=%0d d=%b want 24 1", hits, x_ball, x_ball_dir); end
            end else begin
               total++; if (x_ball !== 10'd608 || x_ball_dir !== 1'b0) begin bad++; $display("FAIL ramp_hitB%0d: got x=%0d d=%b want 608 0", hits, x_ball, x_ball_dir); end
            end
            hits++;
         end
      end
      total++; if (hits != 6) begin bad++; $display("FAIL ramp_count: got %0d hits want 6", hits); end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      #2;
      reset = 1'b0;
      #1;
      total++; if (state !== 2'd0 || x_ball !== 10'd316 || y_ball !== 10'd236) begin bad++; $display("FAIL areset_ball: got st=%0d %0d,%0d want 0 316,236", state, x_ball, y_ball); end
      total++; if (x_ball_vel !== 4'd2 || x_ball_dir !== 1'b1 || y_ball_dir !== 1'b1) begin bad++; $display("FAIL areset_vel: got v=%0d d=%b%b want 2 11", x_ball_vel, x_ball_dir, y_ball_dir); end
      total++; if (y_paddleA !== 10'd208 || y_paddleB !== 10'd208) begin bad++; $display("FAIL areset_pad: got %0d,%0d want 208,208", y_paddleA, y_paddleB); end
      tick(1);
      reset = 1'b1;
   endtask

   // B parks at the top while the ball arrives low.
   task automatic test_point();
      inputB_up = 1'b1;
      tick(60);
      total++; if (state !== 2'd1 || y_paddleB !== 10'd0) begin bad++; $display("FAIL point_setup: got st=%0d pB=%0d want 1 0", state, y_paddleB); end
      inputB_up = 1'b0;
      tick(157);
      total++; if (state !== 2'd1 || x_ball !== 10'd630 || y_ball !== 10'd394) begin bad++; $display("FAIL point_pre: got st=%0d %0d,%0d want 1 630,394", state, x_ball, y_ball); end
      tick(1);
      total++; if (state !== 2'd2 || x_ball !== 10'd632 || lossB !== 1'b1 || lossA !== 1'b0) begin bad++; $display("FAIL point_miss: got st=%0d x=%0d lB=%b lA=%b want 2 632 1 0", state, x_ball, lossB, lossA); end
      total++; if (scoreA !== 3'd1 || scoreB !== 3'd0) begin bad++; $display("FAIL point_score: got %0d,%0d want 1,0", scoreA, scoreB); end
      tick(1);
      total++; if (state !== 2'd0 || x_ball !== 10'd316 || y_ball !== 10'd236 || lossB !== 1'b0) begin bad++; $display("FAIL point_serve: got st=%0d %0d,%0d lB=%b want 0 316,236 0", state, x_ball, y_ball, lossB); end
      total++; if (x_ball_dir !== 1'b1 || y_ball_dir !== 1'b0 || x_ball_vel !== 4'd2) begin bad++; $display("FAIL point_dir: got xd=%b yd=%b v=%0d want 1 0 2", x_ball_dir, y_ball_dir, x_ball_vel); end
   endtask

   // Rallies 2..7: B always sits away from the ball, so A scores each time.
   task automatic test_match_over();
      for (int r = 2; r <= 7; r++) begin
         if (r % 2 == 0) inputB_down = 1'b1;
         else            inputB_up   = 1'b1;
         tick(218);
         total++; if (state !== 2'd2 || scoreA !== 3'(r) || x_ball !== 10'd632) begin bad++; $display("FAIL rally%0d: got st=%0d sA=%0d x=%0d want 2 %0d 632", r, state, scoreA, x_ball, r); end
         clear_inputs();
         tick(1);
         if (r < 7) begin
            total++; if (state !== 2'd0) begin bad++; $display("FAIL rally%0d_serve: got st=%0d want 0", r, state); end
         end
      end
      total++; if (state !== 2'd3 || game_over !== 1'b1 || winner !== 1'b0) begin bad++; $display("FAIL over: got st=%0d go=%b w=%b want 3 1 0", state, game_over, winner); end
      total++; if (scoreA !== 3'd7 || scoreB !== 3'd0) begin bad++; $display("FAIL over_score: got %0d,%0d want 7,0", scoreA, scoreB); end
      inputA_down = 1'b1;
      tick(4);
      total++; if (x_ball !== 10'd632 || y_ball !== 10'd392 || y_paddleA !== 10'd208) begin bad++; $display("FAIL over_frozen: got %0d,%0d pA=%0d want 632,392 208", x_ball, y_ball, y_paddleA); end
      total++; if (state !== 2'd3) begin bad++; $display("FAIL over_stay: got %0d want 3", state); end
      inputA_down = 1'b0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      total++; if (state !== 2'd0 || game_over !== 1'b0 || scoreA !== 3'd0 || scoreB !== 3'd0) begin bad++; $display("FAIL restart: got st=%0d go=%b s=%0d,%0d want 0 0 0,0", state, game_over, scoreA, scoreB); end
      total++; if (x_ball !== 10'd316 || y_ball !== 10'd236 || x_ball_vel !== 4'd2 || y_ball_dir !== 1'b1) begin bad++; $display("FAIL restart_ball: got %0d,%0d v=%0d yd=%b want 316,236 2 1", x_ball, y_ball, x_ball_vel, y_ball_dir); end
      total++; if (y_paddleB !== 10'd0) begin bad++; $display("FAIL restart_pad: got %0d want 0", y_paddleB); end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_paddle_a();
      test_wall();
      test_paddle_hit();
      test_speed_ramp();
      test_async_reset();
      test_point();
      test_match_over();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
